// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: freezes on data-memory waits, flushes on
// taken branches resolved in MEM, inserts load-use bubbles and keeps stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int TO_WIDTH  = 8,
    parameter int TO_LIMIT  = 200,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4:0]           ifid_rs1,
    input  logic [4:0]           ifid_rs2,
    input  logic [4:0]           idex_rd,
    input  logic                 idex_memread,
    input  logic                 exmem_branch,
    input  logic                 exmem_zero,
    input  logic                 exmem_memread,
    input  logic                 exmem_memwrite,
    input  logic                 dmem_ready,
    output logic                 dmem_req,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 idex_bubble,
    output logic                 idex_hold,
    output logic                 exmem_hold,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 exmem_flush,
    output logic                 pc_sel_branch,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    // The wait that brings the counter to TO_LIMIT is the last one before ERROR.
    localparam logic [TO_WIDTH-1:0]  TO_LAST = TO_WIDTH'(TO_LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                state_r;
    state_t                state_next_s;
    logic [TO_WIDTH-1:0]   to_cnt_r;
    logic [CNT_WIDTH-1:0]  stall_cnt_r;
    logic [CNT_WIDTH-1:0]  flush_cnt_r;
    logic                  mem_timeout_r;
    logic                  acc_s;
    logic                  taken_s;
    logic                  load_use_s;
    logic                  freeze_s;
    logic                  to_clear_s;
    logic                  to_inc_s;

    assign acc_s      = exmem_memread | exmem_memwrite;
    assign taken_s    = exmem_branch & exmem_zero;
    assign load_use_s = idex_memread & (idex_rd != 5'd0) &
                        ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

    // Next-state and pipeline control decode, priority ERROR > freeze > branch > load-use.
    always_comb begin
        state_next_s  = state_r;
        freeze_s      = 1'b0;
        to_clear_s    = 1'b0;
        to_inc_s      = 1'b0;
        dmem_req      = 1'b0;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        idex_bubble   = 1'b0;
        idex_hold     = 1'b0;
        exmem_hold    = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        pc_sel_branch = 1'b0;
        case (state_r)
            ST_IDLE: begin
                dmem_req = acc_s;
                if (acc_s && !dmem_ready) begin
                    freeze_s     = 1'b1;
                    to_clear_s   = 1'b1;
                    state_next_s = ST_MEM_WAIT;
                end else if (!acc_s && taken_s) begin
                    pc_sel_branch = 1'b1;
                    ifid_flush    = 1'b1;
                    idex_flush    = 1'b1;
                    exmem_flush   = 1'b1;
                end else if (load_use_s) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    freeze_s = 1'b1;
                    to_inc_s = 1'b1;
                    if (to_cnt_r >= TO_LAST) begin
                        state_next_s = ST_ERROR;
                    end else begin
                        state_next_s = ST_MEM_WAIT;
                    end
                end
            end
            ST_ERROR: begin
                freeze_s     = 1'b1;
                state_next_s = ST_ERROR;
            end
            default: begin
                freeze_s     = 1'b1;
                state_next_s = ST_IDLE;
            end
        endcase
        if (freeze_s) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
        end else begin
            idex_hold  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory-wait timeout counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_r      <= {TO_WIDTH{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            if (to_clear_s) begin
                to_cnt_r <= {TO_WIDTH{1'b0}};
            end else if (to_inc_s) begin
                to_cnt_r <= to_cnt_r + TO_WIDTH'(1);
            end else begin
                to_cnt_r <= to_cnt_r;
            end
            if (state_next_s == ST_ERROR) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
            flush_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (!pc_write && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_WIDTH'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (pc_sel_branch && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_WIDTH'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign mem_timeout  = mem_timeout_r;
    assign stall_cycles = stall_cnt_r;
    assign flush_count  = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: expected control vectors and counter values
// are queued as stimulus is applied and compared against the DUT mid-cycle.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic       idex_memread, exmem_branch, exmem_zero, exmem_memread, exmem_memwrite, dmem_ready;
    logic       dmem_req, pc_write, ifid_write, idex_bubble, idex_hold, exmem_hold;
    logic       ifid_flush, idex_flush, exmem_flush, pc_sel_branch, mem_timeout;
    logic [3:0] stall_cycles, flush_count;
    logic [10:0] ctl_s;

    // {dmem_req, pc_write, ifid_write, idex_bubble, idex_hold, exmem_hold,
    //  ifid_flush, idex_flush, exmem_flush, pc_sel_branch, mem_timeout}
    localparam logic [10:0] NORM = 11'b0_1_1_0_0_0_0_0_0_0_0;
    localparam logic [10:0] ACC  = 11'b1_1_1_0_0_0_0_0_0_0_0;
    localparam logic [10:0] FRZ  = 11'b1_0_0_0_1_1_0_0_0_0_0;
    localparam logic [10:0] ERR  = 11'b0_0_0_0_1_1_0_0_0_0_1;
    localparam logic [10:0] BR   = 11'b0_1_1_0_0_0_1_1_1_1_0;
    localparam logic [10:0] LU   = 11'b0_0_0_1_0_0_0_0_0_0_0;

    typedef struct {
        logic [10:0] ctl;
        logic [3:0]  stall;
        logic [3:0]  flush;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       sb;
    logic [3:0] exp_stall;
    logic [3:0] exp_flush;
    int         checks   = 0;
    int         failures = 0;

    assign ctl_s = {dmem_req, pc_write, ifid_write, idex_bubble, idex_hold, exmem_hold,
                    ifid_flush, idex_flush, exmem_flush, pc_sel_branch, mem_timeout};

    pipeline_hazard_ctrl #(.TO_WIDTH(8), .TO_LIMIT(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
        .idex_memread(idex_memread), .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
        .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_bubble(idex_bubble), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .pc_sel_branch(pc_sel_branch), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic set_inputs(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic idmr, input logic br, input logic zr,
                              input logic mr, input logic mw, input logic rdy);
        ifid_rs1 = rs1; ifid_rs2 = rs2; idex_rd = rd;
        idex_memread = idmr; exmem_branch = br; exmem_zero = zr;
        exmem_memread = mr; exmem_memwrite = mw; dmem_ready = rdy;
    endtask

    // Apply one cycle of stimulus, queue its expectation, advance the counter model, wait mid-cycle.
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic idmr, input logic br, input logic zr,
                         input logic mr, input logic mw, input logic rdy, input logic [10:0] ectl);
        exp_t e;
        @(posedge clk);
        #1;
        set_inputs(rs1, rs2, rd, idmr, br, zr, mr, mw, rdy);
        e.ctl   = ectl;
        e.stall = exp_stall;
        e.flush = exp_flush;
        sb_q.push_back(e);
        if (!ectl[9] && exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
        if (ectl[1] && exp_flush != 4'hF) exp_flush = exp_flush + 4'd1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_inputs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_stall = 4'd0;
        exp_flush = 4'd0;
        @(negedge clk);
        checks++;
        if (ctl_s !== NORM || stall_cycles !== 4'd0 || flush_count !== 4'd0) begin
            failures++;
            $display("FAIL reset ctl=%b exp=%b stall=%0d flush=%0d exp=0/0", ctl_s, NORM, stall_cycles, flush_count);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_no_hazard();
        for (int i = 0; i < 3; i++) begin
            drive(5'(i + 1), 5'(i + 2), 5'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
            sb = sb_q.pop_front();
            checks++;
            if (ctl_s !== sb.ctl || stall_cycles !== sb.stall || flush_count !== sb.flush) begin
                failures++;
                $display("FAIL no_hazard[%0d] ctl=%b exp=%b stall=%0d exp=%0d flush=%0d exp=%0d",
                         i, ctl_s, sb.ctl, stall_cycles, sb.stall, flush_count, sb.flush);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [10:0] e;
        for (int i = 0; i < 6; i++) begin
            e = (i < 3) ? FRZ : (i < 5) ? ACC : NORM;
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, (i < 4), (i == 4), (i >= 3), e);
            sb = sb_q.pop_front();
            checks++;
            if (ctl_s !== sb.ctl || stall_cycles !== sb.stall || flush_count !== sb.flush) begin
                failures++;
                $display("FAIL mem_wait[%0d] ctl=%b exp=%b stall=%0d exp=%0d flush=%0d exp=%0d",
                         i, ctl_s, sb.ctl, stall_cycles, sb.stall, flush_count, sb.flush);
            end
        end
        checks++;
        if (stall_cycles !== 4'd3) begin
            failures++;
            $display("FAIL mem_wait_stall_total got=%0d want=3", stall_cycles);
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BR);
                1: drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU);
                2: drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, ACC);
                default: drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
            endcase
            sb = sb_q.pop_front();
            checks++;
            if (ctl_s !== sb.ctl || stall_cycles !== sb.stall || flush_count !== sb.flush) begin
                failures++;
                $display("FAIL branch[%0d] ctl=%b exp=%b stall=%0d exp=%0d flush=%0d exp=%0d",
                         i, ctl_s, sb.ctl, stall_cycles, sb.stall, flush_count, sb.flush);
            end
        end
        checks++;
        if (flush_count !== 4'd1) begin
            failures++;
            $display("FAIL branch_flush_total got=%0d want=1", flush_count);
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LU);
                1: drive(5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LU);
                2: drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
                default: drive(5'd4, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
            endcase
            sb = sb_q.pop_front();
            checks++;
            if (ctl_s !== sb.ctl || stall_cycles !== sb.stall || flush_count !== sb.flush) begin
                failures++;
                $display("FAIL load_use[%0d] ctl=%b exp=%b stall=%0d exp=%0d flush=%0d exp=%0d",
                         i, ctl_s, sb.ctl, stall_cycles, sb.stall, flush_count, sb.flush);
            end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 26; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (i >= 8), (i < 5) ? FRZ : ERR);
            sb = sb_q.pop_front();
            checks++;
            if (ctl_s !== sb.ctl || stall_cycles !== sb.stall || flush_count !== sb.flush) begin
                failures++;
                $display("FAIL timeout[%0d] ctl=%b exp=%b stall=%0d exp=%0d flush=%0d exp=%0d",
                         i, ctl_s, sb.ctl, stall_cycles, sb.stall, flush_count, sb.flush);
            end
        end
        checks++;
        if (stall_cycles !== 4'd15) begin
            failures++;
            $display("FAIL stall_saturate got=%0d want=15", stall_cycles);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        set_inputs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_stall = 4'd0;
        exp_flush = 4'd0;
        #1;
        checks++;
        if (ctl_s !== NORM || stall_cycles !== 4'd0 || flush_count !== 4'd0) begin
            failures++;
            $display("FAIL error_reset ctl=%b exp=%b stall=%0d flush=%0d", ctl_s, NORM, stall_cycles, flush_count);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
            sb = sb_q.pop_front();
            checks++;
            if (ctl_s !== sb.ctl || stall_cycles !== sb.stall || flush_count !== sb.flush) begin
                failures++;
                $display("FAIL mid_wait[%0d] ctl=%b exp=%b stall=%0d exp=%0d flush=%0d exp=%0d",
                         i, ctl_s, sb.ctl, stall_cycles, sb.stall, flush_count, sb.flush);
            end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        set_inputs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_stall = 4'd0;
        exp_flush = 4'd0;
        #1;
        checks++;
        if (ctl_s !== NORM || stall_cycles !== 4'd0 || flush_count !== 4'd0) begin
            failures++;
            $display("FAIL mid_wait_reset ctl=%b exp=%b stall=%0d flush=%0d", ctl_s, NORM, stall_cycles, flush_count);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, (i == 1), 1'b0, 1'b1, (i == 1) ? ACC : NORM);
            sb = sb_q.pop_front();
            checks++;
            if (ctl_s !== sb.ctl || stall_cycles !== sb.stall || flush_count !== sb.flush) begin
                failures++;
                $display("FAIL after_reset[%0d] ctl=%b exp=%b stall=%0d exp=%0d flush=%0d exp=%0d",
                         i, ctl_s, sb.ctl, stall_cycles, sb.stall, flush_count, sb.flush);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_mem_wait();
        test_branch();
        test_load_use();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
